// File: rtl/gpr_cdb_arb_pkg.sv
// gpr_cdb_arb_pkg: widths and the CDB payload type shared by the GPR result
// producers, the CDB arbiter and every CDB consumer (register file, ROB,
// reservation stations).
//   ROB_WIDTH      - width of a ROB tag
//   XLEN           - width of a GPR result
//   N_GPR_CDB_REQ  - number of producers on the GPR CDB (mov, alu, load, fpu->gpr)
//   cdb_t          - broadcast payload {valid, tag, data}
package gpr_cdb_arb_pkg;

    localparam int unsigned ROB_WIDTH     = 6;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned N_GPR_CDB_REQ = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } cdb_t;

endpackage

// File: rtl/gpr_cdb_arb_if.sv
// gpr_cdb_arb_if: producer request bundle plus the GPR CDB broadcast.
//   req_valid [N_REQ]     - producer has a result ready to broadcast
//   req_ready [N_REQ]     - per-producer grant (dispatch = valid && ready)
//   req_tag   [N_REQ]     - ROB tag, presented alongside req_valid
//   req_data  [N_REQ]     - producer result register, valid the cycle after grant
//   gpr_cdb               - broadcast to register file / ROB / reservation stations
// Modports: master = producer side, slave = arbiter side.
interface gpr_cdb_arb_if
    import gpr_cdb_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_GPR_CDB_REQ
);

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
    logic [N_REQ-1:0][XLEN-1:0]      req_data;
    cdb_t                            gpr_cdb;

    modport master (
        output req_valid,
        output req_tag,
        output req_data,
        input  req_ready,
        input  gpr_cdb
    );

    modport slave (
        input  req_valid,
        input  req_tag,
        input  req_data,
        output req_ready,
        output gpr_cdb
    );

endinterface

// File: rtl/gpr_cdb_arb_rr_pick.sv
// rr_pick: combinational one-hot picker. Scans the request vector starting at
// i_start, wrapping past N-1 back to 0, and grants the first set bit.
//   i_req   [N]      - request vector
//   i_start [IDX_W]  - index the scan starts from (must be < N)
//   o_gnt_c [N]      - one-hot grant, all zero when i_req is zero
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_gnt_c
);

    int unsigned w_idx;
    logic        w_found;

    // First requester at or after i_start, modulo N.
    always_comb begin
        o_gnt_c = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(i_start) + k) % N;
            if (!w_found && i_req[IDX_W'(w_idx)]) begin
                o_gnt_c[IDX_W'(w_idx)] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_cdb_arb.sv
// gpr_cdb_arb: arbitrates the GPR result producers onto the single GPR CDB.
// A grant at edge t captures the winner's index and ROB tag; in cycle t+1 the
// CDB carries that tag with the winner's result register, which the producer
// has loaded by then. One grant per cycle, so full throughput is sustained.
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   flush  - synchronous misprediction flush; blocks grants this cycle
//   bus    - gpr_cdb_arb_if.slave (req_valid/req_ready/req_tag/req_data, gpr_cdb)
// Build option: define GPR_CDB_ARB_RR_EN for round-robin arbitration; without
// it the lowest requesting index wins.
module gpr_cdb_arb
    import gpr_cdb_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_GPR_CDB_REQ
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    gpr_cdb_arb_if.slave  bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                 r_valid_q;
    logic [ROB_WIDTH-1:0] r_tag_q;
    logic [IDX_W-1:0]     r_gnt_idx;

    logic [N_REQ-1:0]     w_req;
    logic [N_REQ-1:0]     w_gnt;
    logic [IDX_W-1:0]     w_start;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_any;

    // Nothing competes during flush or while reset is held.
    assign w_req = (flush || !reset) ? '0 : bus.req_valid;

`ifdef GPR_CDB_ARB_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;

    assign w_start = r_rr_ptr;

    // Point just past the winner, wrapping at N_REQ.
    assign w_rr_ptr_nxt = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    // Priority pointer advances only when something is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_any) begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end
`else
    assign w_start = '0;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_start (w_start),
        .o_gnt_c (w_gnt)
    );

    // One-hot grant to index.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDX_W'(i);
            end
        end
    end

    assign bus.req_ready = w_gnt;

    // Broadcast stage: tag and index captured at grant, held across idle edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_q <= 1'b0;
            r_tag_q   <= '0;
            r_gnt_idx <= '0;
        end else begin
            r_valid_q <= w_gnt_any;
            if (w_gnt_any) begin
                r_tag_q   <= bus.req_tag[w_gnt_idx];
                r_gnt_idx <= w_gnt_idx;
            end
        end
    end

    // Data comes straight from the winner's result register one cycle after grant.
    assign bus.gpr_cdb = '{valid: r_valid_q, tag: r_tag_q, data: bus.req_data[r_gnt_idx]};

endmodule

// File: tb/tb_gpr_cdb_arb.sv
// tb_gpr_cdb_arb: scoreboard bench for gpr_cdb_arb. The stimulus process drives
// one cycle at a time, computes the expected grant from the arbitration rule and
// queues the expected req_ready and the expected broadcast; an independent
// monitor samples on the falling edge and compares against the queues.
// Follows GPR_CDB_ARB_RR_EN the same way the design does.
module tb_gpr_cdb_arb;
    import gpr_cdb_arb_pkg::*;

    localparam int N = 4;

    typedef struct {
        int             cyc;
        logic [N-1:0]   rdy;
    } rdy_e_t;

    typedef struct {
        int                   cyc;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } bc_e_t;

    logic clk;
    logic rst_n;
    logic flush;

    gpr_cdb_arb_if #(.N_REQ(N)) bus ();

    gpr_cdb_arb #(.N_REQ(N)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit run = 0;
    bit in_reset = 0;

    rdy_e_t rdy_q[$];
    bc_e_t  bc_q[$];

    // Reference state: next index to search from, and result registers.
    int                     ptr = 0;
    logic [N-1:0][31:0]     data_cur;
    int                     ovr_idx = -1;
    logic [ROB_WIDTH-1:0]   ovr_tag;
    logic [31:0]            ovr_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // First requester at or after start, wrapping modulo N; -1 when none.
    function automatic int model_pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int idx = (start + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input bit f);
        int                 g;
        logic [N-1:0][31:0] data_nxt;
        rdy_e_t             re;
        bc_e_t              be;
        @(posedge clk);
        #1;
        bus.req_valid = v;
        flush         = f;
        for (int i = 0; i < N; i++) bus.req_tag[i] = ROB_WIDTH'($urandom);
        bus.req_data  = data_cur;
        for (int i = 0; i < N; i++) data_nxt[i] = $urandom;
        if (ovr_idx >= 0) begin
            bus.req_tag[ovr_idx] = ovr_tag;
            data_nxt[ovr_idx]    = ovr_data;
            ovr_idx              = -1;
        end
`ifdef GPR_CDB_ARB_RR_EN
        g = f ? -1 : model_pick(v, ptr);
`else
        g = f ? -1 : model_pick(v, 0);
`endif
        re.cyc = cyc;
        re.rdy = '0;
        if (g >= 0) re.rdy[g] = 1'b1;
        rdy_q.push_back(re);
        if (g >= 0) begin
            be.cyc  = cyc + 1;
            be.tag  = bus.req_tag[g];
            be.data = data_nxt[g];
            bc_q.push_back(be);
            ptr = (g + 1) % N;
        end
        data_cur = data_nxt;
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (run && rst_n && !in_reset) begin
            if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
                rdy_e_t e;
                e = rdy_q.pop_front();
                chk("req_ready", 32'(bus.req_ready), 32'(e.rdy));
            end
            if (bc_q.size() > 0 && bc_q[0].cyc == cyc) begin
                bc_e_t b;
                b = bc_q.pop_front();
                chk("cdb_valid", 32'(bus.gpr_cdb.valid), 32'd1);
                chk("cdb_tag",   32'(bus.gpr_cdb.tag),   32'(b.tag));
                chk("cdb_data",  bus.gpr_cdb.data,       b.data);
            end else begin
                chk("cdb_idle", 32'(bus.gpr_cdb.valid), 32'd0);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '1;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        data_cur      = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_valid", 32'(bus.gpr_cdb.valid), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;

        // Single request with fixed tag/data.
        ovr_idx = 1; ovr_tag = ROB_WIDTH'(5); ovr_data = 32'h1234;
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        // All requesting.
        repeat (5) step(4'b1111, 1'b0);
        // Requesters 1 and 3.
        repeat (3) step(4'b1010, 1'b0);
        // Flush on the cycle carrying a broadcast.
        step(4'b0100, 1'b0);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b0);
        // Idle gaps.
        repeat (4) begin
            step(4'b0100, 1'b0);
            step(4'b0000, 1'b0);
        end

        // Random traffic.
        repeat (300) step(N'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));

        // Asynchronous reset while a broadcast is on the CDB.
        step(4'b1111, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_valid", 32'(bus.gpr_cdb.valid), 32'd1);
        bus.req_valid = '0;
        in_reset      = 1'b1;
        rst_n         = 1'b0;
        rdy_q.delete();
        bc_q.delete();
        #1;
        chk("async_reset_valid", 32'(bus.gpr_cdb.valid), 32'd0);
        chk("async_reset_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        ptr      = 0;
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);

        repeat (100) step(N'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        repeat (3) step(4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rdy_q_drained", 32'(rdy_q.size()), 32'd0);
        chk("bc_q_drained",  32'(bc_q.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
